// File: rtl/pwrv_dac0_gen.sv
// pwrv_dac0_gen: turns the committed PWRCTL target plus the region offset
// trim into the DAC0 code. An optional half-LSB dither alternates the code
// between base and base+1 with a selectable period and duty.
module pwrv_dac0_gen #(
    parameter int PRESC = 8,   // clk cycles per dither tick (>=1)
    parameter int CW    = 11   // DAC0 code width
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic [CW-1:0] pwr_v,
    input  logic          pwr_hlsb,
    input  logic          pwr_we,
    input  logic [15:0]   cvofs,
    input  logic [1:0]    xtm_freq,
    input  logic          xtm_duty,
    output logic [CW-1:0] dac0_code,
    output logic          dac0_upd
);

    localparam int            TW        = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(PRESC - 1);
    localparam logic [CW-1:0] CODE_MAX  = {CW{1'b1}};

    // Shadow of the committed target
    logic [CW-1:0] tgt_q;
    logic          hlsb_q;

    // Dither timing
    logic [TW-1:0] tick_q;
    logic [3:0]    phase_q;
    logic [1:0]    freq_q;

    // Output stage
    logic [CW-1:0] code_q;
    logic          upd_q;

    // Combinational helpers
    logic [3:0]    ofs_arr [4];
    logic [1:0]    region;
    logic [3:0]    ofs_sel;
    logic [CW:0]   sum;
    logic [CW-1:0] base;
    logic [CW-1:0] hi;
    logic [3:0]    phase_mask;
    logic [3:0]    hi_limit;
    logic          tick_wrap;
    logic          phase_clr;
    logic          sel_hi;
    logic [CW-1:0] code_d;

    // Split the packed offset word into its four 4-bit trims
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ofs
            assign ofs_arr[gi] = cvofs[gi*4 +: 4];
        end
    endgenerate

    // Region select on the full target width; everything from 768 up uses ofs3
    always_comb begin
        region = 2'd3;
        if (tgt_q < CW'(256)) begin
            region = 2'd0;
        end else if (tgt_q < CW'(512)) begin
            region = 2'd1;
        end else if (tgt_q < CW'(768)) begin
            region = 2'd2;
        end
    end

    assign ofs_sel = ofs_arr[region];
    assign sum     = {1'b0, tgt_q} + (CW+1)'(ofs_sel);
    assign base    = sum[CW] ? CODE_MAX : sum[CW-1:0];
    assign hi      = (base == CODE_MAX) ? CODE_MAX : base + CW'(1);

    // Period mask (P-1) and the count of high phases for the chosen duty
    always_comb begin
        phase_mask = 4'b0001;
        hi_limit   = 4'd1;
        case (xtm_freq)
            2'd0: begin phase_mask = 4'b0001; hi_limit = xtm_duty ? 4'd0 : 4'd1; end
            2'd1: begin phase_mask = 4'b0011; hi_limit = xtm_duty ? 4'd1 : 4'd2; end
            2'd2: begin phase_mask = 4'b0111; hi_limit = xtm_duty ? 4'd2 : 4'd4; end
            default: begin phase_mask = 4'b1111; hi_limit = xtm_duty ? 4'd4 : 4'd8; end
        endcase
    end

    assign tick_wrap = (tick_q == TICK_LAST);
    assign phase_clr = pwr_we || (xtm_freq != freq_q);
    assign sel_hi    = hlsb_q && (phase_q < hi_limit);
    assign code_d    = sel_hi ? hi : base;

    // Commit point: pwr_v / pwr_hlsb only take effect on the write strobe
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            tgt_q  <= '0;
            hlsb_q <= 1'b0;
        end else if (pwr_we) begin
            tgt_q  <= pwr_v;
            hlsb_q <= pwr_hlsb;
        end
    end

    // Prescaler; restarted on commit so the first high phase is a full tick
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            tick_q <= '0;
        end else if (pwr_we || tick_wrap) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + TW'(1);
        end
    end

    // Phase counter modulo P; a commit or period change restarts it (commit wins over tick)
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            phase_q <= '0;
            freq_q  <= '0;
        end else begin
            freq_q <= xtm_freq;
            if (phase_clr) begin
                phase_q <= '0;
            end else if (tick_wrap) begin
                phase_q <= (phase_q + 4'd1) & phase_mask;
            end
        end
    end

    // Registered output code and change pulse
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            code_q <= '0;
            upd_q  <= 1'b0;
        end else begin
            code_q <= code_d;
            upd_q  <= (code_d != code_q);
        end
    end

    assign dac0_code = code_q;
    assign dac0_upd  = upd_q;

endmodule

// File: tb/tb_pwrv_dac0_gen.sv
// Bench for pwrv_dac0_gen: a cycle model built from the offset/saturation and
// dither rules, compared every cycle, plus hand-computed directed checks.
module tb_pwrv_dac0_gen;

    localparam int PRESC = 8;
    localparam int CW    = 11;

    logic          clk = 1'b0;
    logic          rstz = 1'b0;
    logic [CW-1:0] pwr_v = '0;
    logic          pwr_hlsb = 1'b0;
    logic          pwr_we = 1'b0;
    logic [15:0]   cvofs = '0;
    logic [1:0]    xtm_freq = '0;
    logic          xtm_duty = 1'b0;
    logic [CW-1:0] dac0_code;
    logic          dac0_upd;

    int n_assert = 0;
    int n_fail   = 0;

    pwrv_dac0_gen #(.PRESC(PRESC), .CW(CW)) dut (
        .clk       (clk),
        .rstz      (rstz),
        .pwr_v     (pwr_v),
        .pwr_hlsb  (pwr_hlsb),
        .pwr_we    (pwr_we),
        .cvofs     (cvofs),
        .xtm_freq  (xtm_freq),
        .xtm_duty  (xtm_duty),
        .dac0_code (dac0_code),
        .dac0_upd  (dac0_upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_t = 0, m_h = 0, m_cyc = 0, m_ticks = 0, m_fq = 0;
    int m_code = 0, m_upd = 0;
    int mo, mbase, mhi, mp, mpq, mthr, mnxt;
    bit mtick;

    initial begin
        forever begin
            @(posedge clk or negedge rstz);
            if (!rstz) begin
                m_t = 0; m_h = 0; m_cyc = 0; m_ticks = 0; m_fq = 0;
                m_code = 0; m_upd = 0;
            end else begin
                if (m_t < 256)      mo = int'(cvofs[3:0]);
                else if (m_t < 512) mo = int'(cvofs[7:4]);
                else if (m_t < 768) mo = int'(cvofs[11:8]);
                else                mo = int'(cvofs[15:12]);
                mbase = (m_t + mo > 2047) ? 2047 : m_t + mo;
                mhi   = (mbase + 1 > 2047) ? 2047 : mbase + 1;
                mp    = 2 << int'(xtm_freq);
                mpq   = 2 << m_fq;
                mthr  = xtm_duty ? mp / 4 : mp / 2;
                mnxt  = (m_h != 0 && (m_ticks % mpq) < mthr) ? mhi : mbase;
                m_upd  = (mnxt != m_code) ? 1 : 0;
                m_code = mnxt;
                if (pwr_we) begin
                    m_t = int'(pwr_v); m_h = int'(pwr_hlsb);
                    m_cyc = 0; m_ticks = 0;
                end else begin
                    mtick = ((m_cyc % PRESC) == PRESC - 1);
                    m_cyc++;
                    if (int'(xtm_freq) != m_fq) m_ticks = 0;
                    else if (mtick)             m_ticks++;
                end
                m_fq = int'(xtm_freq);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rstz) begin
                chk("rst_code", 32'(dac0_code), 0);
                chk("rst_upd", 32'(dac0_upd), 0);
            end else begin
                chk("model_code", 32'(dac0_code), 32'(m_code));
                chk("model_upd", 32'(dac0_upd), 32'(m_upd));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle commit; returns #1 after the latching edge
    task automatic write(input int v, input bit h);
        pwr_v    = CW'(v);
        pwr_hlsb = h;
        pwr_we   = 1'b1;
        @(posedge clk);
        #1;
        pwr_we   = 1'b0;
    endtask

    int pulses;
    int t3_in  [6] = '{255, 256, 511, 512, 768, 2040};
    int t3_exp [6] = '{258, 266, 521, 517, 783, 2047};

    initial begin
        wait_cyc(3);
        rstz = 1'b1;

        // 1: idle after reset
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            wait_cyc(1);
            if (dac0_upd) pulses++;
        end
        chk("t1_no_upd", 32'(pulses), 0);
        chk("t1_code", 32'(dac0_code), 0);

        // 2: plain writes, zero offset, N+2 latency and single pulse
        write(300, 1'b0);
        chk("t2_n1_old", 32'(dac0_code), 0);
        wait_cyc(1);
        chk("t2_code300", 32'(dac0_code), 300);
        chk("t2_upd", 32'(dac0_upd), 1);
        wait_cyc(1);
        chk("t2_upd_once", 32'(dac0_upd), 0);
        write(600, 1'b0);
        wait_cyc(1);
        chk("t2_code600", 32'(dac0_code), 600);

        // 3: region boundaries and saturation
        cvofs = 16'hF5A3;
        for (int i = 0; i < 6; i++) begin
            write(t3_in[i], 1'b0);
            wait_cyc(1);
            chk($sformatf("t3_t%0d", t3_in[i]), 32'(dac0_code), 32'(t3_exp[i]));
        end
        // live offset: ofs2 change visible one cycle after sampling
        write(512, 1'b0);
        wait_cyc(1);
        cvofs = 16'hFFA3;
        wait_cyc(1);
        chk("t3_live_ofs", 32'(dac0_code), 527);

        // 4: half-LSB dither, P=4
        cvofs = 16'h2000; xtm_freq = 2'd1; xtm_duty = 1'b0;
        write(1000, 1'b1);
        wait_cyc(1);  chk("t4_d0_hi_first", 32'(dac0_code), 1003);
        wait_cyc(15); chk("t4_d0_hi_last", 32'(dac0_code), 1003);
        wait_cyc(1);  chk("t4_d0_lo_first", 32'(dac0_code), 1002);
        wait_cyc(15); chk("t4_d0_lo_last", 32'(dac0_code), 1002);
        wait_cyc(1);  chk("t4_d0_hi_again", 32'(dac0_code), 1003);
        xtm_duty = 1'b1;
        write(1000, 1'b1);
        wait_cyc(1);  chk("t4_d1_hi_first", 32'(dac0_code), 1003);
        wait_cyc(7);  chk("t4_d1_hi_last", 32'(dac0_code), 1003);
        wait_cyc(1);  chk("t4_d1_lo_first", 32'(dac0_code), 1002);
        wait_cyc(23); chk("t4_d1_lo_last", 32'(dac0_code), 1002);
        wait_cyc(1);  chk("t4_d1_hi_again", 32'(dac0_code), 1003);
        // period changes mid-dither, then P=2 at 25% which never goes high
        xtm_freq = 2'd3; xtm_duty = 1'b0;
        wait_cyc(45);
        xtm_freq = 2'd2;
        wait_cyc(30);
        xtm_freq = 2'd0; xtm_duty = 1'b1;
        wait_cyc(2);
        for (int i = 0; i < 10; i++) begin
            wait_cyc(1);
            chk("t4_p2_d25_base", 32'(dac0_code), 1002);
        end

        // 5: saturated target, base==hi, no dither activity
        xtm_freq = 2'd1; xtm_duty = 1'b0;
        write(2047, 1'b1);
        wait_cyc(1);
        chk("t5_code", 32'(dac0_code), 2047);
        chk("t5_upd", 32'(dac0_upd), 1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            wait_cyc(1);
            if (dac0_upd) pulses++;
            if (dac0_code != 11'd2047) pulses += 100;
        end
        chk("t5_constant", 32'(pulses), 0);

        // 6: async reset mid-dither, then uncommitted pwr_v
        write(1000, 1'b1);
        wait_cyc(1);
        chk("t6_pre_rst", 32'(dac0_code), 1003);
        wait_cyc(3);
        rstz = 1'b0;
        #1;
        chk("t6_async_rst", 32'(dac0_code), 0);
        wait_cyc(2);
        rstz = 1'b1;
        pwr_v = 11'd500;
        wait_cyc(5);
        chk("t6_no_commit", 32'(dac0_code), 0);
        chk("t6_no_upd", 32'(dac0_upd), 0);

        wait_cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
